addr_bus_arbiter: RTL and testbench

ADDR_BUS_ARBITER -- requirements
Module: addr_bus_arbiter

---
 rtl/addr_bus_arbiter_pkg.sv | 31 +++
 rtl/addr_bus_arbiter_rr_pick5.sv | 27 ++
 rtl/addr_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_addr_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_bus_arbiter_pkg.sv
// Shared types and constants for the five-driver address bus arbiter.
package addr_bus_arbiter_pkg;

  localparam int unsigned NUM_DRIVERS = 5;
  localparam int unsigned DRV_IDX_W   = 3;
  localparam int unsigned CNT_W       = 4;

  localparam logic [DRV_IDX_W-1:0] DRV_M   = 3'd0;
  localparam logic [DRV_IDX_W-1:0] DRV_XY  = 3'd1;
  localparam logic [DRV_IDX_W-1:0] DRV_J   = 3'd2;
  localparam logic [DRV_IDX_W-1:0] DRV_PC  = 3'd3;
  localparam logic [DRV_IDX_W-1:0] DRV_INC = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    VALID  = 2'd2,
    TURN   = 2'd3
  } arb_state_e;

  // Index of the set bit in a one-hot driver vector (0 when empty).
  function automatic logic [DRV_IDX_W-1:0] onehot_to_idx(input logic [NUM_DRIVERS-1:0] oh);
    logic [DRV_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_DRIVERS; i++) begin
      if (oh[i]) idx = DRV_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/addr_bus_arbiter_rr_pick5.sv
// Combinational round-robin picker: first set request after the last winner.
module rr_pick5
  import addr_bus_arbiter_pkg::*;
(
  input  logic [NUM_DRIVERS-1:0] req,
  input  logic [DRV_IDX_W-1:0]   last,
  output logic [NUM_DRIVERS-1:0] gnt_next
);

  logic                 found;
  logic [DRV_IDX_W-1:0] idx;

  // Scan (last+1) .. (last+5) modulo 5 and keep the first requester.
  always_comb begin
    gnt_next = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= NUM_DRIVERS; k++) begin
      idx = DRV_IDX_W'((32'(last) + k) % NUM_DRIVERS);
      if (!found && req[idx]) begin
        gnt_next[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addr_bus_arbiter.sv
// Address bus arbiter: round-robin grant, relay settle delay, turnaround cycle.
module addr_bus_arbiter
  import addr_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BUS_WIDTH = 16,
  parameter int unsigned SETTLE_CYCLES  = 2
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_DRIVERS-1:0]                req,
  input  logic [NUM_DRIVERS*ADDR_BUS_WIDTH-1:0] drv_addr,
  output logic [NUM_DRIVERS-1:0]                gnt,
  output logic [ADDR_BUS_WIDTH-1:0]             addr,
  output logic                                  addr_valid,
  output logic                                  busy,
  output logic                                  abort_err
);

  arb_state_e                state_q, state_d;
  logic [NUM_DRIVERS-1:0]    gnt_q, gnt_d;
  logic [DRV_IDX_W-1:0]      gidx_q, gidx_d;
  logic [DRV_IDX_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_BUS_WIDTH-1:0] addr_q, addr_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      abort_q, abort_d;
  logic [NUM_DRIVERS-1:0]    pick;
  logic [ADDR_BUS_WIDTH-1:0] drv_slice [NUM_DRIVERS];

  // Split the flat address input into per-driver words.
  for (genvar i = 0; i < NUM_DRIVERS; i++) begin : g_slice
    assign drv_slice[i] = drv_addr[i*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH];
  end

  rr_pick5 u_pick (
    .req      (req),
    .last     (last_q),
    .gnt_next (pick)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = pick;
          gidx_d  = onehot_to_idx(pick);
          last_d  = gidx_d;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // A dropped request wins over the counter expiring.
        if (!req[gidx_q]) begin
          abort_d = 1'b1;
          gnt_d   = '0;
          state_d = TURN;
        end else if (cnt_q == '0) begin
          state_d = VALID;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      VALID: begin
        if (!req[gidx_q]) begin
          gnt_d   = '0;
          state_d = TURN;
        end
      end
      TURN: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    addr_d  = (gnt_d != '0) ? drv_slice[gidx_d] : '0;
    valid_d = (state_d == VALID);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; reset parks the bus with M next in line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      last_q  <= DRV_INC;
      cnt_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      abort_q <= abort_d;
    end
  end

  assign gnt        = gnt_q;
  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign abort_err  = abort_q;

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Bench for addr_bus_arbiter: default build and a SETTLE_CYCLES=1 build side by side.
module tb_addr_bus_arbiter;

  localparam int W = 16;
  localparam int N = 5;
  localparam int SETTLE_OF [2] = '{2, 1};

  logic           clock;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] drv_addr;

  logic [N-1:0] gnt0, gnt1;
  logic [W-1:0] addr0, addr1;
  logic         av0, av1, busy0, busy1, ab0, ab1;

  int tests = 0;
  int fails = 0;

  // Transaction-level reference: owner, cycles since grant, turnaround flag.
  int          m_owner [2];
  int          m_age   [2];
  int          m_last  [2];
  bit          m_turn  [2];
  bit          m_abort [2];
  logic [W-1:0] m_addr [2];

  addr_bus_arbiter #(.ADDR_BUS_WIDTH(W), .SETTLE_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .req(req), .drv_addr(drv_addr),
    .gnt(gnt0), .addr(addr0), .addr_valid(av0), .busy(busy0), .abort_err(ab0)
  );

  addr_bus_arbiter #(.ADDR_BUS_WIDTH(W), .SETTLE_CYCLES(1)) dut_s1 (
    .clock(clock), .reset(reset), .req(req), .drv_addr(drv_addr),
    .gnt(gnt1), .addr(addr1), .addr_valid(av1), .busy(busy1), .abort_err(ab1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_age[k]   = 0;
      m_last[k]  = 4;
      m_turn[k]  = 1'b0;
      m_abort[k] = 1'b0;
      m_addr[k]  = '0;
    end
  endtask

  // One clock of the reference, using the inputs present at the edge.
  task automatic model_step(input int k);
    bit found;
    int i;
    m_abort[k] = 1'b0;
    if (m_turn[k]) begin
      m_turn[k] = 1'b0;
    end else if (m_owner[k] < 0) begin
      found = 1'b0;
      for (int off = 1; off <= N; off++) begin
        i = (m_last[k] + off) % N;
        if (!found && req[i]) begin
          found      = 1'b1;
          m_owner[k] = i;
          m_last[k]  = i;
          m_age[k]   = 0;
        end
      end
    end else if (!req[m_owner[k]]) begin
      m_abort[k] = (m_age[k] < SETTLE_OF[k]);
      m_owner[k] = -1;
      m_turn[k]  = 1'b1;
    end else if (m_age[k] < SETTLE_OF[k]) begin
      m_age[k]++;
    end
    m_addr[k] = (m_owner[k] >= 0) ? drv_addr[m_owner[k]*W +: W] : '0;
  endtask

  function automatic logic [23:0] exp_vec(input int k);
    logic [4:0] g;
    logic v, b;
    g = (m_owner[k] >= 0) ? 5'(1 << m_owner[k]) : 5'd0;
    v = (m_owner[k] >= 0) && (m_age[k] >= SETTLE_OF[k]);
    b = (m_owner[k] >= 0) || m_turn[k];
    return {g, m_addr[k], v, b, m_abort[k]};
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_s2"}, 32'({gnt0, addr0, av0, busy0, ab0}), 32'(exp_vec(0)));
    check({tag, "_s1"}, 32'({gnt1, addr1, av1, busy1, ab1}), 32'(exp_vec(1)));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    compare_all("cyc");
  endtask

  // Called just after an edge: pulses reset entirely between clock edges.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    model_reset();
    compare_all(tag);
    #2;
    reset = 1'b0;
  endtask

  logic [4:0] rr_exp [6];
  logic [4:0] prevg;
  int         nk;

  initial begin
    rr_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    reset    = 1'b1;
    req      = '0;
    drv_addr = {$urandom, $urandom, $urandom};
    model_reset();
    #12;
    compare_all("reset_state");
    check("reset_busy", 32'(busy0), 32'(0));
    reset = 1'b0;

    // Single PC request.
    do_reset("rst_single");
    drv_addr[3*W +: W] = 16'h1234;
    req = 5'b01000;
    cycle();
    check("single_gnt", 32'(gnt0), 32'(5'b01000));
    check("single_nv0", 32'(av0), 32'(0));
    cycle();
    check("single_nv1", 32'(av0), 32'(0));
    check("s1_latency", 32'(av1), 32'(1));
    cycle();
    check("single_valid", 32'(av0), 32'(1));
    check("single_addr", 32'(addr0), 32'(16'h1234));
    req = '0;
    repeat (3) cycle();

    // Contention after reset: rotation M, XY, J, PC, INC, M.
    do_reset("rst_rr");
    req   = 5'b11111;
    prevg = '0;
    nk    = 0;
    for (int c = 0; c < 100 && nk < 6; c++) begin
      cycle();
      if (gnt0 != '0 && prevg == '0) begin
        check($sformatf("rr_grant%0d", nk), 32'(gnt0), 32'(rr_exp[nk]));
        nk++;
      end
      prevg = gnt0;
      req   = 5'b11111;
      if (m_owner[0] >= 0 && m_age[0] >= SETTLE_OF[0]) req[m_owner[0]] = 1'b0;
    end
    check("rr_count", 32'(nk), 32'(6));
    req = '0;
    repeat (4) cycle();

    // Early drop of XY during settle.
    do_reset("rst_abort");
    req = 5'b00010;
    cycle();
    check("abort_gnt", 32'(gnt0), 32'(5'b00010));
    req = '0;
    cycle();
    check("abort_pulse", 32'(ab0), 32'(1));
    check("abort_turn_gnt", 32'(gnt0), 32'(0));
    check("abort_turn_busy", 32'(busy0), 32'(1));
    check("abort_nv", 32'(av0), 32'(0));
    cycle();
    check("abort_clear", 32'(ab0), 32'(0));
    check("abort_idle", 32'(busy0), 32'(0));
    check("abort_nv2", 32'(av0), 32'(0));

    // J holds the bus while M waits.
    do_reset("rst_hold");
    drv_addr[2*W +: W] = 16'hABCD;
    req = 5'b00100;
    repeat (3) cycle();
    check("hold_valid", 32'(av0), 32'(1));
    req = 5'b00101;
    for (int c = 0; c < 10; c++) begin
      cycle();
      check($sformatf("hold_gnt%0d", c), 32'(gnt0), 32'(5'b00100));
      check($sformatf("hold_addr%0d", c), 32'(addr0), 32'(16'hABCD));
    end
    req = 5'b00001;
    cycle();
    check("hold_turn", 32'(gnt0), 32'(0));
    cycle();
    check("hold_idle", 32'(gnt0), 32'(0));
    cycle();
    check("hold_m_gnt", 32'(gnt0), 32'(5'b00001));
    req = '0;
    repeat (3) cycle();

    // Reset asserted while M is valid.
    do_reset("rst_midv");
    drv_addr[0*W +: W] = 16'h5A5A;
    req = 5'b00001;
    repeat (3) cycle();
    check("midv_valid", 32'(av0), 32'(1));
    #3;
    reset = 1'b1;
    #1;
    check("midv_gnt", 32'(gnt0), 32'(0));
    check("midv_addr", 32'(addr0), 32'(0));
    check("midv_av", 32'(av0), 32'(0));
    check("midv_abort", 32'(ab0), 32'(0));
    model_reset();
    #2;
    reset = 1'b0;
    req = 5'b11111;
    cycle();
    check("midv_first_m", 32'(gnt0), 32'(5'b00001));
    req = '0;
    repeat (4) cycle();

    // Random traffic against the reference.
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(0, 7) == 0) drv_addr = {$urandom, $urandom, $urandom};
      cycle();
      if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
